// File: rtl/valu_sequencer.sv
// valu_sequencer: issue-side controller for the vector lane ALU.
// Streams one vector instruction (vd = vs1 op vs2) element by element through
// a two-stage pipeline: read -> ALU/stage-1 register -> write-back, then
// reports the accumulated element flags with a one-cycle done pulse.
module valu_sequencer #(
  parameter int vdw_p      = 32,
  parameter int op_len_p   = 2,
  parameter int els_p      = 16,
  parameter int num_regs_p = 8
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic                                          v_i,
  output logic                                          ready_o,
  input  logic [op_len_p-1:0]                           op_i,
  input  logic [$clog2(num_regs_p)-1:0]                 vd_i,
  input  logic [$clog2(num_regs_p)-1:0]                 vs1_i,
  input  logic [$clog2(num_regs_p)-1:0]                 vs2_i,
  output logic [$clog2(num_regs_p)+$clog2(els_p)-1:0]   r_addr_a_o,
  output logic [$clog2(num_regs_p)+$clog2(els_p)-1:0]   r_addr_b_o,
  output logic                                          r_v_o,
  input  logic [vdw_p-1:0]                              r_data_a_i,
  input  logic [vdw_p-1:0]                              r_data_b_i,
  output logic [vdw_p-1:0]                              alu_a_o,
  output logic [vdw_p-1:0]                              alu_b_o,
  output logic [op_len_p-1:0]                           alu_op_o,
  input  logic [vdw_p-1:0]                              alu_result_i,
  input  logic                                          alu_overflow_i,
  input  logic                                          alu_zero_i,
  input  logic                                          alu_negative_i,
  output logic                                          w_v_o,
  output logic [$clog2(num_regs_p)+$clog2(els_p)-1:0]   w_addr_o,
  output logic [vdw_p-1:0]                              w_data_o,
  output logic                                          done_o,
  output logic                                          flag_overflow_o,
  output logic                                          flag_zero_o,
  output logic                                          flag_negative_o,
  output logic                                          err_o
);

  localparam int elem_w = $clog2(els_p);
  localparam int reg_w  = $clog2(num_regs_p);

  localparam logic [op_len_p-1:0] op_illegal = op_len_p'(3);
  localparam logic [elem_w-1:0]   last_k     = elem_w'(els_p - 1);

  typedef enum logic [1:0] {eIdle, eRun, eDone} state_e;

  state_e state_q, state_n;

  // Latched command
  logic [op_len_p-1:0] op_q;
  logic [reg_w-1:0]    vd_q, vs1_q, vs2_q;

  // Read issue counter; rd_done_q marks that element els_p-1 has been issued
  logic [elem_w-1:0] k_q;
  logic              rd_done_q;

  // Stage 1 tracks the element whose read data arrives this cycle
  logic              s1_v_q;
  logic [elem_w-1:0] s1_k_q;

  // Stage 2 holds the registered ALU result being written back
  logic              s2_v_q;
  logic [elem_w-1:0] s2_k_q;
  logic [vdw_p-1:0]  s2_data_q;
  logic              s2_ovf_q, s2_zero_q, s2_neg_q;

  // Accumulated summary flags
  logic acc_ovf_q, acc_zero_q, acc_neg_q, err_q;

  logic accept;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset_i) state_q <= eIdle;
    else         state_q <= state_n;
  end

  // Next-state and control outputs
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_n = state_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    r_v_o   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      eIdle: begin
        ready_o = 1'b1;
        if (v_i) begin
          accept  = 1'b1;
          state_n = (op_i == op_illegal) ? eDone : eRun;
        end
      end
      eRun: begin
        r_v_o = !rd_done_q;
        // Leave after the last element's write-back cycle
        if (s2_v_q && (s2_k_q == last_k)) state_n = eDone;
      end
      eDone: begin
        done_o  = 1'b1;
        state_n = eIdle;
      end
      default: state_n = eIdle;
    endcase
  end

  // Command latch, read counter, pipeline stages and flag accumulation
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q       <= '0;
      vd_q       <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      k_q        <= '0;
      rd_done_q  <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_k_q     <= '0;
      s2_v_q     <= 1'b0;
      s2_k_q     <= '0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_neg_q   <= 1'b0;
      acc_ovf_q  <= 1'b0;
      acc_zero_q <= 1'b0;
      acc_neg_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op_i;
        vd_q       <= vd_i;
        vs1_q      <= vs1_i;
        vs2_q      <= vs2_i;
        k_q        <= '0;
        rd_done_q  <= 1'b0;
        acc_ovf_q  <= 1'b0;
        acc_zero_q <= 1'b1;
        acc_neg_q  <= 1'b0;
        err_q      <= (op_i == op_illegal);
      end

      if (r_v_o) begin
        k_q <= k_q + 1'b1;
        if (k_q == last_k) rd_done_q <= 1'b1;
      end

      s1_v_q <= r_v_o;
      s1_k_q <= k_q;

      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_k_q    <= s1_k_q;
        s2_data_q <= alu_result_i;
        s2_ovf_q  <= alu_overflow_i;
        s2_zero_q <= alu_zero_i;
        s2_neg_q  <= alu_negative_i;
      end

      if (s2_v_q) begin
        acc_ovf_q  <= acc_ovf_q  | s2_ovf_q;
        acc_zero_q <= acc_zero_q & s2_zero_q;
        acc_neg_q  <= acc_neg_q  | s2_neg_q;
      end
    end
  end

  // Register file, ALU and write-back drive
  always_comb begin
    r_addr_a_o      = r_v_o ? {vs1_q, k_q} : '0;
    r_addr_b_o      = r_v_o ? {vs2_q, k_q} : '0;
    alu_a_o         = s1_v_q ? r_data_a_i : '0;
    alu_b_o         = s1_v_q ? r_data_b_i : '0;
    alu_op_o        = op_q;
    w_v_o           = s2_v_q;
    w_addr_o        = {vd_q, s2_k_q};
    w_data_o        = s2_data_q;
    flag_overflow_o = acc_ovf_q;
    flag_zero_o     = acc_zero_q;
    flag_negative_o = acc_neg_q;
    err_o           = err_q;
  end

endmodule

// File: tb/tb_valu_sequencer.sv
// Directed bench for valu_sequencer with a registered-read register file and
// a combinational lane ALU modelled around the DUT.
module tb_valu_sequencer;

  localparam int dw = 32;
  localparam int nels = 16;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              v_i;
  logic              ready_o;
  logic [1:0]        op_i;
  logic [2:0]        vd_i, vs1_i, vs2_i;
  logic [6:0]        r_addr_a_o, r_addr_b_o;
  logic              r_v_o;
  logic [dw-1:0]     r_data_a_i, r_data_b_i;
  logic [dw-1:0]     alu_a_o, alu_b_o;
  logic [1:0]        alu_op_o;
  logic [dw-1:0]     alu_result_i;
  logic              alu_overflow_i, alu_zero_i, alu_negative_i;
  logic              w_v_o;
  logic [6:0]        w_addr_o;
  logic [dw-1:0]     w_data_o;
  logic              done_o;
  logic              flag_overflow_o, flag_zero_o, flag_negative_o, err_o;

  int total = 0;
  int bad = 0;

  // Bench-side register file with a preload port
  logic [dw-1:0] mem [0:127];
  logic          pre_we;
  logic [6:0]    pre_addr;
  logic [dw-1:0] pre_data;

  logic [dw-1:0] exp_w [0:nels-1];

  always #5 clk_i = ~clk_i;

  valu_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .op_i(op_i), .vd_i(vd_i), .vs1_i(vs1_i), .vs2_i(vs2_i),
    .r_addr_a_o(r_addr_a_o), .r_addr_b_o(r_addr_b_o), .r_v_o(r_v_o),
    .r_data_a_i(r_data_a_i), .r_data_b_i(r_data_b_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_overflow_i(alu_overflow_i),
    .alu_zero_i(alu_zero_i), .alu_negative_i(alu_negative_i),
    .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .done_o(done_o), .flag_overflow_o(flag_overflow_o),
    .flag_zero_o(flag_zero_o), .flag_negative_o(flag_negative_o),
    .err_o(err_o)
  );

  // Register file: read data one cycle after r_v_o, write on w_v_o
  always @(posedge clk_i) begin
    if (r_v_o) begin
      r_data_a_i <= mem[r_addr_a_o];
      r_data_b_i <= mem[r_addr_b_o];
    end
    if (w_v_o)  mem[w_addr_o] <= w_data_o;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  // Lane ALU: unsigned carry/borrow/high-half overflow convention
  logic [dw:0]     alu_sum;
  logic [2*dw-1:0] alu_prod;
  always_comb begin
    alu_sum        = '0;
    alu_prod       = '0;
    alu_result_i   = '0;
    alu_overflow_i = 1'b0;
    case (alu_op_o)
      2'd0: begin
        alu_sum        = {1'b0, alu_a_o} + {1'b0, alu_b_o};
        alu_result_i   = alu_sum[dw-1:0];
        alu_overflow_i = alu_sum[dw];
      end
      2'd1: begin
        alu_result_i   = alu_a_o - alu_b_o;
        alu_overflow_i = (alu_a_o < alu_b_o);
      end
      2'd2: begin
        alu_prod       = {32'b0, alu_a_o} * {32'b0, alu_b_o};
        alu_result_i   = alu_prod[dw-1:0];
        alu_overflow_i = |alu_prod[2*dw-1:dw];
      end
      default: ;
    endcase
    alu_zero_i     = (alu_result_i == '0);
    alu_negative_i = alu_result_i[dw-1];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [2:0] r, input int e, input logic [dw-1:0] d);
    pre_we   = 1'b1;
    pre_addr = {r, 4'(e)};
    pre_data = d;
    @(negedge clk_i);
    pre_we   = 1'b0;
  endtask

  // Issue one legal command at the current negedge and check every cycle of
  // its schedule against exp_w and the expected flags.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [2:0] vd,
                         input logic [2:0] vs1, input logic [2:0] vs2, input bit hold,
                         input bit e_ovf, input bit e_zero, input bit e_neg);
    string t;
    v_i = 1'b1; op_i = op; vd_i = vd; vs1_i = vs1; vs2_i = vs2;
    check({name, " accept ready"}, ready_o, 1);
    for (int i = 1; i <= nels + 5; i++) begin
      @(negedge clk_i);
      // While busy, optionally keep offering an illegal command that must be ignored
      v_i = hold && (i < nels + 3);
      if (hold) begin op_i = 2'd3; vd_i = 3'd7; vs1_i = 3'd7; vs2_i = 3'd7; end
      t = $sformatf("%s c+%0d", name, i);
      check({t, " r_v"}, r_v_o, (i >= 1 && i <= nels));
      check({t, " w_v"}, w_v_o, (i >= 3 && i <= nels + 2));
      check({t, " done"}, done_o, (i == nels + 3));
      check({t, " ready"}, ready_o, (i >= nels + 4));
      if (i >= 1 && i <= nels) begin
        check({t, " r_addr_a"}, r_addr_a_o, {vs1, 4'(i - 1)});
        check({t, " r_addr_b"}, r_addr_b_o, {vs2, 4'(i - 1)});
      end
      if (i >= 3 && i <= nels + 2) begin
        check({t, " w_addr"}, w_addr_o, {vd, 4'(i - 3)});
        check({t, " w_data"}, w_data_o, exp_w[i-3]);
      end
      if (i == nels + 3) begin
        check({t, " overflow"}, flag_overflow_o, e_ovf);
        check({t, " zero"}, flag_zero_o, e_zero);
        check({t, " negative"}, flag_negative_o, e_neg);
        check({t, " err"}, err_o, 0);
      end
    end
    v_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; op_i = '0; vd_i = '0; vs1_i = '0; vs2_i = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    @(negedge clk_i);
    @(negedge clk_i);

    // Reset state
    check("rst ready", ready_o, 1);
    check("rst r_v", r_v_o, 0);
    check("rst w_v", w_v_o, 0);
    check("rst done", done_o, 0);
    check("rst flags", {flag_overflow_o, flag_zero_o, flag_negative_o, err_o}, 0);
    check("rst w_addr", w_addr_o, 0);
    check("rst w_data", w_data_o, 0);
    check("rst r_addr", {r_addr_a_o, r_addr_b_o}, 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Add: k + 2k = 3k
    for (int k = 0; k < nels; k++) begin
      load(3'd1, k, 32'(k));
      load(3'd2, k, 32'(2 * k));
      exp_w[k] = 32'(3 * k);
    end
    run_cmd("add", 2'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal op: done+err next cycle, no register file traffic
    v_i = 1'b1; op_i = 2'd3; vd_i = 3'd0; vs1_i = 3'd1; vs2_i = 3'd2;
    check("ill accept ready", ready_o, 1);
    @(negedge clk_i);
    v_i = 1'b0;
    check("ill c+1 done", done_o, 1);
    check("ill c+1 err", err_o, 1);
    check("ill c+1 r_v", r_v_o, 0);
    check("ill c+1 w_v", w_v_o, 0);
    check("ill c+1 ready", ready_o, 0);
    @(negedge clk_i);
    check("ill c+2 ready", ready_o, 1);
    check("ill c+2 done", done_o, 0);
    check("ill c+2 r_v/w_v", {r_v_o, w_v_o}, 0);

    // Sub: 5 - 5 = 0 everywhere
    for (int k = 0; k < nels; k++) begin
      load(3'd4, k, 32'd5);
      exp_w[k] = 32'd0;
    end
    run_cmd("sub", 2'd1, 3'd5, 3'd4, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mult: element 7 overflows to 0, the rest are 3*(k+1)
    for (int k = 0; k < nels; k++) begin
      load(3'd6, k, (k == 7) ? 32'h0001_0000 : 32'(k + 1));
      load(3'd7, k, (k == 7) ? 32'h0001_0000 : 32'd3);
      exp_w[k] = (k == 7) ? 32'd0 : 32'(3 * (k + 1));
    end
    run_cmd("mul", 2'd2, 3'd0, 3'd6, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);

    // In-place add: reg1 (0..15) += 1
    for (int k = 0; k < nels; k++) begin
      load(3'd5, k, 32'd1);
      exp_w[k] = 32'(k + 1);
    end
    run_cmd("inplace", 2'd0, 3'd1, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < nels; k++)
      check($sformatf("inplace mem[%0d]", k), mem[{3'd1, 4'(k)}], 32'(k + 1));

    // Sub with borrow: 1 - (k+1) = -k
    for (int k = 0; k < nels; k++) exp_w[k] = 32'(-k);
    run_cmd("subneg", 2'd1, 3'd4, 3'd5, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a run
    v_i = 1'b1; op_i = 2'd0; vd_i = 3'd3; vs1_i = 3'd1; vs2_i = 3'd2;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      v_i = 1'b0;
    end
    check("rstmid c+8 w_v", w_v_o, 1);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("rstmid c+9 w_v", w_v_o, 0);
    check("rstmid c+9 r_v", r_v_o, 0);
    check("rstmid c+9 done", done_o, 0);
    check("rstmid c+9 ready", ready_o, 1);
    check("rstmid c+9 w_addr", w_addr_o, 0);
    for (int i = 10; i <= 24; i++) begin
      @(negedge clk_i);
      check($sformatf("rstmid c+%0d w_v/done", i), {w_v_o, done_o}, 0);
    end

    // New command after reset, with v_i held high while busy
    for (int k = 0; k < nels; k++) exp_w[k] = 32'(3 * k + 1);
    run_cmd("hold", 2'd0, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    check("hold after r_v/done/err", {r_v_o, done_o, err_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
